// File: rtl/concat_word_packer.sv
// concat_word_packer
// Accepts {tag, payload} pairs over a valid/ready handshake, buffers them in a
// small show-ahead FIFO and presents the packed word {tag, payload} downstream.
// Also keeps a wrapping count of delivered words and supports a synchronous
// flush that empties the FIFO without disturbing that count.

module concat_word_packer #(
  parameter int TAG_W  = 2,
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_W+DATA_W-1:0]     out_word,
  output logic [$clog2(DEPTH):0]      level,
  output logic [7:0]                  word_cnt
);

  localparam int WORD_W = TAG_W + DATA_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  typedef logic [WORD_W-1:0] word_t;

  // Storage and pointer state
  word_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q,  level_d;
  logic [7:0]        word_cnt_q, word_cnt_d;

  logic push;
  logic pop;

  // Handshake qualifiers come from registered occupancy only (plus flush),
  // so out_ready never reaches in_ready combinationally.
  assign in_ready  = (level_q != LVL_W'(DEPTH)) & ~flush;
  assign out_valid = (level_q != '0);

  assign push = in_valid  & in_ready;
  assign pop  = out_valid & out_ready;

  // Show-ahead: the head entry is always on the output port.
  assign out_word = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign word_cnt = word_cnt_q;

  // Next-state for pointers, occupancy and the delivered-word counter
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    // A pop during flush still counts: that word was delivered.
    word_cnt_d = word_cnt_q + 8'(pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset deliberately so the show-ahead output is never X.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {in_tag, in_data};
    end
  end

endmodule

// File: tb/tb_concat_word_packer.sv
// Testbench for concat_word_packer: directed scenarios plus randomised
// traffic, all checked against a queue-based reference model.

module tb_concat_word_packer;

  localparam int TAG_W  = 2;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 4;
  localparam int WORD_W = TAG_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]        word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO contents as a queue, delivered words as a plain count
  logic [WORD_W-1:0] model_q [$];
  int                model_cnt = 0;

  concat_word_packer #(
    .TAG_W (TAG_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_tag   (in_tag),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .level    (level),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_cnt = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, take the edge,
  // then advance the model. Entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [TAG_W-1:0] tag,
                       input logic [DATA_W-1:0] data, input logic rdy, input logic fl);
    bit exp_ready;
    bit exp_valid;
    in_valid  = v;
    in_tag    = tag;
    in_data   = data;
    out_ready = rdy;
    flush     = fl;
    #1;
    exp_ready = (model_q.size() != DEPTH) && !fl;
    exp_valid = (model_q.size() != 0);
    check("in_ready",  in_ready,  exp_ready);
    check("out_valid", out_valid, exp_valid);
    check("level",     level,     model_q.size());
    check("word_cnt",  word_cnt,  model_cnt % 256);
    if (exp_valid) check("out_word", out_word, model_q[0]);
    @(posedge clk);
    if (exp_valid && rdy) begin
      void'(model_q.pop_front());
      model_cnt++;
    end
    if (fl) model_q.delete();
    else if (v && exp_ready) model_q.push_back({tag, data});
    #1;
  endtask

  task automatic check_reset_values(input string phase);
    check({phase, "_in_ready"},  in_ready,  1);
    check({phase, "_out_valid"}, out_valid, 0);
    check({phase, "_level"},     level,     0);
    check({phase, "_word_cnt"},  word_cnt,  0);
    check({phase, "_out_word"},  out_word,  0);
  endtask

  initial begin
    logic [TAG_W-1:0]  t_arr [5];
    logic [DATA_W-1:0] d_arr [5];
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] d1;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_tag = '0; in_data = '0;
    model_reset();
    #2;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single push with downstream stalled: one-cycle latency, exact packing
    t1 = 2'b10;
    d1 = 10'h155;
    cycle(1'b1, t1, d1, 1'b0, 1'b0);
    check("t1_word",      out_word,        {t1, d1});
    check("t1_split_b",   out_word[11:1],  {t1, d1[9:1]});
    check("t1_split_c",   out_word[0],     d1[0]);
    check("t1_out_valid", out_valid,       1);
    check("t1_level",     level,           1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("t1_drained", level, 0);

    // Five pushes into a stalled FIFO: four accepted, fifth waits for a pop
    for (int i = 0; i < 5; i++) begin
      t_arr[i] = TAG_W'($urandom);
      d_arr[i] = DATA_W'($urandom);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, t_arr[i], d_arr[i], 1'b0, 1'b0);
    check("full_level",    level,    DEPTH);
    check("full_in_ready", in_ready, 0);
    cycle(1'b1, t_arr[4], d_arr[4], 1'b1, 1'b0);   // pop only, still full before edge
    cycle(1'b1, t_arr[4], d_arr[4], 1'b1, 1'b0);   // fifth pair accepted here
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("burst_word_cnt", word_cnt, 6);
    check("burst_empty",    out_valid, 0);

    // Steady push+pop at level 2 for 300 cycles; counter wraps
    rst = 1'b1;
    model_reset();
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, TAG_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    cycle(1'b1, TAG_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      cycle(1'b1, TAG_W'($urandom), DATA_W'($urandom), 1'b1, 1'b0);
    check("stream_level",    level,    2);
    check("stream_word_cnt", word_cnt, 44);

    // Flush at level 3 with a concurrent pop
    cycle(1'b1, TAG_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    check("pre_flush_level", level, 3);
    cycle(1'b1, TAG_W'($urandom), DATA_W'($urandom), 1'b1, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("flush_level",     level,     0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready",  in_ready,  1);
    check("flush_word_cnt",  word_cnt,  45);
    @(posedge clk); #1;

    // Asynchronous reset between edges with three words buffered
    for (int i = 0; i < 3; i++) cycle(1'b1, TAG_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    check("pre_rst_level", level, 3);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    t1 = TAG_W'($urandom);
    d1 = DATA_W'($urandom);
    cycle(1'b1, t1, d1, 1'b0, 1'b0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_word",  out_word,  {t1, d1});
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), TAG_W'($urandom), DATA_W'($urandom),
            1'($urandom), ($urandom_range(0, 31) == 0));
    for (int i = 0; i <= DEPTH; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("final_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
